data_mem_arbiter: RTL and testbench

//  Shares the single-port 256x8 data memory between two requesters: port 0 (CPU load/store

---
 rtl/data_mem_arbiter.sv | 117 +++++++++++
 tb/tb_data_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: picks a winner, runs one
// memory access cycle, then pulses the winner's ack with read data held on rdata.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prio_mode,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    // Handshake: a requester raises req[i] with we/addr/wdata stable and holds them until
    // ack[i] pulses for one cycle; a req still high in the following IDLE is a new request.

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                last_grant_q, last_grant_d;
    logic                winner;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        winner       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie, round-robin favours the port that did not win last time.
                    if (req == 2'b11) begin
                        winner = prio_mode ? 1'b0 : ~last_grant_q;
                    end else begin
                        winner = req[1];
                    end
                    owner_d      = winner;
                    we_d         = winner ? we[1]  : we[0];
                    addr_d       = winner ? addr1  : addr0;
                    wdata_d      = winner ? wdata1 : wdata0;
                    last_grant_d = winner;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = mem_data_out;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write enable is also gated by reset_n so a reset edge can never commit a write.
    assign mem_read_enable  = (state_q == ST_ACCESS) && !we_q;
    assign mem_write_enable = (state_q == ST_ACCESS) && we_q && reset_n;
    assign mem_address      = addr_q;
    assign mem_data_in      = wdata_q;
    assign ack              = (state_q == ST_ACK) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy             = (state_q != ST_IDLE);
    assign rdata            = rdata_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 256x8 data memory attached.
module tb_data_mem_arbiter;

  logic       clk;
  logic       reset_n;
  logic       prio_mode;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy;
  logic       mem_read_enable, mem_write_enable;
  logic [7:0] mem_address, mem_data_in;
  wire  [7:0] mem_data_out;
  logic [1:0] dbg_state;

  logic [7:0] mem [256];
  logic       mem_init;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic       port;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .prio_mode(prio_mode), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .busy(busy),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // data memory model: combinational read, Z when not enabled
  assign mem_data_out = mem_read_enable ? mem[mem_address] : 8'hzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // driver: one single-port transaction with cycle-exact checks
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req[v.port] = 1'b1;
    we[v.port]  = v.wr;
    if (v.port) begin
      addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      addr0 = v.addr; wdata0 = v.wdata;
    end
    @(negedge clk);
    chk("access_state", dbg_state, 1);
    chk("access_busy", busy, 1);
    chk("access_ack", ack, 0);
    chk("access_re", mem_read_enable, !v.wr);
    chk("access_we", mem_write_enable, v.wr);
    chk("access_addr", mem_address, v.addr);
    if (v.wr) chk("access_wdata", mem_data_in, v.wdata);
    @(negedge clk);
    chk("ack_pulse", ack, v.port ? 2'b10 : 2'b01);
    chk("ack_busy", busy, 1);
    chk("ack_rdata", rdata, v.exp_rdata);
    chk("ack_re", mem_read_enable, 0);
    chk("ack_we", mem_write_enable, 0);
    req[v.port] = 1'b0;
    @(negedge clk);
    chk("idle_ack", ack, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rdata", rdata, v.exp_rdata);
    if (v.wr) chk("mem_commit", mem[v.addr], v.wdata);
  endtask

  initial begin
    int got;
    int last_cyc;
    logic [1:0] e;

    reset_n = 1'b0; prio_mode = 1'b0; req = 2'b00; we = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    mem_init = 1'b1;

    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h3C, 8'hA5};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h5E, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5E};
    vecs[6] = '{1'b0, 1'b1, 8'h80, 8'hC3, 8'h5E};
    vecs[7] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'hC3};

    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    reset_n  = 1'b1;
    chk("rst_state", dbg_state, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re", mem_read_enable, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // reset during the ACCESS cycle of a write: memory untouched, no ack
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr0 = 8'h20; wdata0 = 8'h77;
    @(negedge clk);
    chk("rst_mid_state", dbg_state, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_mem", mem[8'h20], 8'h7A);
    chk("rst_mid_rdata", rdata, 0);
    req[0] = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_noack", ack, 0);
    run_vec('{1'b0, 1'b0, 8'h20, 8'h00, 8'h7A});

    // round-robin with both ports holding req: order 0,1,0,1, one ack per 3 cycles
    do_reset();
    prio_mode = 1'b0;
    we = 2'b00; addr0 = 8'h10; addr1 = 8'hFF;
    exp_q = {2'd0, 2'd1, 2'd0, 2'd1};
    got = 0; last_cyc = 0;
    req = 2'b11;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        e = exp_q.pop_front();
        chk("rr_onehot", (ack == 2'b01) || (ack == 2'b10), 1);
        chk("rr_order", {1'b0, ack[1]}, e);
        chk("rr_rdata", rdata, ack[1] ? 8'h3C : 8'hA5);
        if (got > 0) chk("rr_interval", cyc - last_cyc, 3);
        last_cyc = cyc;
        got++;
        if (got == 4) req = 2'b00;
      end
    end
    chk("rr_ack_count", got, 4);
    repeat (3) @(negedge clk);
    chk("rr_idle", busy, 0);

    // fixed priority: port 1 starves until port 0 drops its request
    prio_mode = 1'b1;
    exp_q = {2'd0, 2'd0, 2'd0, 2'd1};
    got = 0; last_cyc = 0;
    req = 2'b11;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        e = exp_q.pop_front();
        chk("fp_order", {1'b0, ack[1]}, e);
        if (got > 0) chk("fp_interval", cyc - last_cyc, 3);
        last_cyc = cyc;
        got++;
        if (ack[0] && got == 3) req[0] = 1'b0;
        if (ack[1]) req[1] = 1'b0;
      end
    end
    chk("fp_ack_count", got, 4);
    repeat (3) @(negedge clk);
    chk("fp_idle_ack", ack, 0);
    chk("fp_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
